// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
//   boot_state_t     : boot protocol phase (length, code, acknowledge, data)
//   DEFAULT_ACK_BYTE : byte sent to the host once the code segment is loaded
//   WORD_BYTES       : bytes per assembled little-endian word
package uart_boot_pkg;

    typedef enum logic [1:0] {
        LEN  = 2'd0,
        CODE = 2'd1,
        ACK  = 2'd2,
        DATA = 2'd3
    } boot_state_t;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
    localparam int         WORD_BYTES       = 4;

endpackage

// File: rtl/uart_word_packer.sv
// Packs a UART byte stream into little-endian 32-bit words.
// The n-th byte of a word lands in word[8n+7:8n]. The word is presented
// combinationally on the cycle its fourth byte arrives.
// Optional feature macro: UART_BOOT_TIMEOUT_EN drops a partial word after
// TIMEOUT_CYCLES idle cycles.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   i_rx_valid/data  : received byte strobe and value
//   o_word_valid     : high for the cycle a word completes
//   o_word           : completed word (valid with o_word_valid)
module uart_word_packer
    import uart_boot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_word_packer: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  r_index;
    logic [23:0] r_hold;

    // Bytes shift in from the top, so after three bytes r_hold = {b2, b1, b0}.
    assign o_word_valid = i_rx_valid && (r_index == 2'(WORD_BYTES - 1));
    assign o_word       = {i_rx_data, r_hold};

`ifdef UART_BOOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle;

    // Down-counter reloaded on every byte; expiring with a partial word
    // pending discards that partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_index <= 2'd0;
            r_hold  <= 24'd0;
            r_idle  <= '0;
        end else if (i_rx_valid) begin
            r_index <= r_index + 2'd1;
            r_hold  <= {i_rx_data, r_hold[23:8]};
            r_idle  <= TW'(TIMEOUT_CYCLES - 1);
        end else if (r_index != 2'd0) begin
            if (r_idle == '0) begin
                r_index <= 2'd0;
            end else begin
                r_idle <= r_idle - TW'(1);
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            r_index <= 2'd0;
            r_hold  <= 24'd0;
        end else if (i_rx_valid) begin
            r_index <= r_index + 2'd1;
            r_hold  <= {i_rx_data, r_hold[23:8]};
        end
    end
`endif

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader front end for the memory controller hub.
// Protocol: one length word N, then min(N, MAX_INSTR_WORDS) instruction
// words, then a single acknowledge byte on the UART transmitter, then
// free-running data words until reset.
// Optional feature macro: UART_BOOT_TIMEOUT_EN (partial-word idle timeout
// in the byte packer).
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   rx_valid, rx_data     : received byte strobe and value
//   instr_ready           : pulse, data holds an instruction word
//   mem_ready             : pulse, data holds an input data word
//   data                  : last assembled word
//   program_loaded        : level, set when the acknowledge is issued
//   tx_start, sdata       : one-shot transmit request and byte
//   tx_busy               : UART transmitter busy
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int         MAX_INSTR_WORDS = 1024,
    parameter logic [7:0] ACK_BYTE        = DEFAULT_ACK_BYTE,
    parameter int         TIMEOUT_CYCLES  = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        instr_ready,
    output logic        mem_ready,
    output logic [31:0] data,
    output logic        program_loaded,
    output logic        tx_start,
    output logic [7:0]  sdata,
    input  logic        tx_busy
);

    localparam int CW = $clog2(MAX_INSTR_WORDS + 1);

    logic          w_word_valid;
    logic [31:0]   w_word;
    logic [CW-1:0] w_clamped;

    boot_state_t   r_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_data;
    logic          r_instr_ready;
    logic          r_mem_ready;
    logic          r_tx_start;
    logic [7:0]    r_sdata;
    logic          r_program_loaded;

    uart_word_packer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_packer (
        .clock        (clock),
        .reset        (reset),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // The full 32-bit length is compared before narrowing to the counter.
    assign w_clamped = (w_word > 32'(MAX_INSTR_WORDS)) ? CW'(MAX_INSTR_WORDS)
                                                       : w_word[CW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= LEN;
            r_count          <= '0;
            r_data           <= 32'd0;
            r_instr_ready    <= 1'b0;
            r_mem_ready      <= 1'b0;
            r_tx_start       <= 1'b0;
            r_sdata          <= 8'd0;
            r_program_loaded <= 1'b0;
        end else begin
            r_instr_ready <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_tx_start    <= 1'b0;

            // Words are classified by the state held before this edge, so a
            // word arriving during ACK is already a data word.
            if (w_word_valid) begin
                r_data <= w_word;
                case (r_state)
                    LEN: begin
                        r_count <= w_clamped;
                        r_state <= (w_clamped == '0) ? ACK : CODE;
                    end
                    CODE: begin
                        r_instr_ready <= 1'b1;
                        r_count       <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= ACK;
                        end
                    end
                    default: begin
                        r_mem_ready <= 1'b1;
                    end
                endcase
            end

            // Only reachable from ACK, never from a word-driven transition
            // in the same cycle, so the two state writes cannot collide.
            if ((r_state == ACK) && !tx_busy) begin
                r_tx_start       <= 1'b1;
                r_sdata          <= ACK_BYTE;
                r_program_loaded <= 1'b1;
                r_state          <= DATA;
            end
        end
    end

    assign instr_ready    = r_instr_ready;
    assign mem_ready      = r_mem_ready;
    assign data           = r_data;
    assign tx_start       = r_tx_start;
    assign sdata          = r_sdata;
    assign program_loaded = r_program_loaded;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

    localparam int         MAXW = 1024;
    localparam int         TO   = 50;
    localparam logic [7:0] ACKB = 8'hAA;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_busy = 1'b0;
    logic        instr_ready, mem_ready, program_loaded, tx_start;
    logic [31:0] data;
    logic [7:0]  sdata;

    uart_boot_loader #(
        .MAX_INSTR_WORDS (MAXW),
        .ACK_BYTE        (ACKB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .instr_ready    (instr_ready),
        .mem_ready      (mem_ready),
        .data           (data),
        .program_loaded (program_loaded),
        .tx_start       (tx_start),
        .sdata          (sdata),
        .tx_busy        (tx_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Word k after the length word is an instruction iff k <= min(N, MAX).
    logic [7:0]  m_buf [4];
    int          m_bytes, m_words, m_idle;
    longint      m_n;
    bit          m_code_done;
    logic        e_instr = 0, e_mem = 0, e_tx = 0, e_pl = 0;
    logic [31:0] e_data = 0;
    logic [7:0]  e_sdata = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_bytes = 0; m_words = 0; m_idle = 0; m_n = 0; m_code_done = 0;
            e_instr = 0; e_mem = 0; e_tx = 0; e_pl = 0; e_data = 0; e_sdata = 0;
        end else begin
            e_instr = 0; e_mem = 0; e_tx = 0;
            if (m_code_done && !e_pl && !tx_busy) begin
                e_tx = 1; e_pl = 1; e_sdata = ACKB;
            end
            if (rx_valid) begin
                m_idle = 0;
                m_buf[m_bytes] = rx_data;
                m_bytes++;
                if (m_bytes == 4) begin
                    m_bytes = 0;
                    e_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                    if (m_words == 0) begin
                        m_n = (longint'(e_data) > MAXW) ? MAXW : longint'(e_data);
                        if (m_n == 0) m_code_done = 1;
                    end else if (m_words <= m_n) begin
                        e_instr = 1;
                        if (m_words == m_n) m_code_done = 1;
                    end else begin
                        e_mem = 1;
                    end
                    m_words++;
                end
            end
`ifdef UART_BOOT_TIMEOUT_EN
            else if (m_bytes != 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_bytes = 0;
                    m_idle  = 0;
                end
            end
`endif
        end
    end

    // ---------------- compare process + event logs ----------------
    logic [31:0] q_instr[$];
    logic [31:0] q_mem[$];
    int          q_mem_cyc[$];
    int          tx_cnt = 0;
    int          tx_cyc = 0;

    always @(negedge clock) begin
        chk("instr_ready", instr_ready, e_instr);
        chk("mem_ready", mem_ready, e_mem);
        chk("data", data, e_data);
        chk("tx_start", tx_start, e_tx);
        chk("sdata", sdata, e_sdata);
        chk("program_loaded", program_loaded, e_pl);
        chk("ready_exclusive", instr_ready & mem_ready, 1'b0);
        if (instr_ready === 1'b1) q_instr.push_back(data);
        if (mem_ready === 1'b1) begin
            q_mem.push_back(data);
            q_mem_cyc.push_back(cyc);
        end
        if (tx_start === 1'b1) begin
            tx_cnt++;
            tx_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr_logs();
        q_instr.delete();
        q_mem.delete();
        q_mem_cyc.delete();
        tx_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clr_logs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            idle($urandom_range(maxgap, 0));
        end
    endtask

    initial begin
        logic [31:0] w;
        int          c0, n, nw;

        @(negedge clock);

        // Length 2, two instruction words, acknowledge.
        do_reset();
        tx_busy = 1'b0;
        send_word(32'd2, 2);
        send_word(32'h04030201, 2);
        send_word(32'h08070605, 2);
        idle(3);
        chk("s1_instr_count", q_instr.size(), 2);
        if (q_instr.size() == 2) begin
            chk("s1_word0", q_instr[0], 32'h04030201);
            chk("s1_word1", q_instr[1], 32'h08070605);
        end
        chk("s1_tx_count", tx_cnt, 1);
        chk("s1_sdata", sdata, 8'hAA);
        chk("s1_loaded", program_loaded, 1'b1);

        // Length 0 with transmitter busy, then a data word.
        do_reset();
        tx_busy = 1'b1;
        send_word(32'd0, 0);
        idle(10);
        chk("s2_no_tx_while_busy", tx_cnt, 0);
        chk("s2_not_loaded", program_loaded, 1'b0);
        c0 = cyc;
        tx_busy = 1'b0;
        @(negedge clock);
        #1;
        chk("s2_tx_count", tx_cnt, 1);
        chk("s2_tx_cycle", tx_cyc, c0 + 1);
        send_word(32'hEFBEADDE, 1);
        idle(2);
        chk("s2_instr_none", q_instr.size(), 0);
        chk("s2_mem_count", q_mem.size(), 1);
        if (q_mem.size() == 1) chk("s2_mem_word", q_mem[0], 32'hEFBEADDE);

        // Length 2000 clamps to 1024; word 1025 is data.
        do_reset();
        send_word(32'd2000, 0);
        w = 0;
        for (int k = 0; k < 1025; k++) begin
            tx_busy = 1'($urandom_range(1, 0));
            w = $urandom;
            send_word(w, 1);
        end
        tx_busy = 1'b0;
        idle(3);
        chk("s3_instr_count", q_instr.size(), 1024);
        chk("s3_mem_count", q_mem.size(), 1);
        if (q_mem.size() == 1) chk("s3_mem_word", q_mem[0], w);
        chk("s3_tx_count", tx_cnt, 1);

        // Reset two bytes into a code word.
        do_reset();
        send_word(32'd3, 1);
        send_word($urandom, 1);
        send_byte(8'h5A);
        send_byte(8'hC3);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("s4_rst_instr", instr_ready, 1'b0);
        chk("s4_rst_mem", mem_ready, 1'b0);
        chk("s4_rst_data", data, 32'd0);
        chk("s4_rst_tx", tx_start, 1'b0);
        chk("s4_rst_sdata", sdata, 8'd0);
        chk("s4_rst_loaded", program_loaded, 1'b0);
        reset = 1'b0;
        clr_logs();
        send_word(32'd1, 1);
        w = $urandom;
        send_word(w, 1);
        send_word(32'h13572468, 1);
        idle(3);
        chk("s4_instr_count", q_instr.size(), 1);
        if (q_instr.size() == 1) chk("s4_instr_word", q_instr[0], w);
        chk("s4_mem_count", q_mem.size(), 1);
        chk("s4_tx_count", tx_cnt, 1);

        // Partial word followed by a long idle gap.
        do_reset();
        send_word(32'd0, 0);
        idle(2);
        clr_logs();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        idle(TO);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        idle(2);
        chk("s5_mem_count", q_mem.size(), 1);
`ifdef UART_BOOT_TIMEOUT_EN
        if (q_mem.size() == 1) chk("s5_word", q_mem[0], 32'h77665544);
`else
        if (q_mem.size() == 1) chk("s5_word", q_mem[0], 32'h44332211);
`endif

        // Back-to-back bytes in DATA.
        do_reset();
        send_word(32'd0, 0);
        idle(3);
        clr_logs();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        idle(2);
        chk("s6_mem_count", q_mem.size(), 2);
        if (q_mem_cyc.size() == 2) chk("s6_mem_spacing", q_mem_cyc[1] - q_mem_cyc[0], 4);
        chk("s6_instr_none", q_instr.size(), 0);

        // Randomised sessions.
        for (int s = 0; s < 8; s++) begin
            do_reset();
            n  = $urandom_range(5, 0);
            nw = n + $urandom_range(4, 1);
            send_word(32'(n), 3);
            for (int k = 0; k < nw; k++) begin
                tx_busy = 1'($urandom_range(1, 0));
                send_word($urandom, 3);
            end
            tx_busy = 1'b0;
            idle(3);
            chk("s7_instr_count", q_instr.size(), n);
            chk("s7_mem_count", q_mem.size(), nw - n);
            chk("s7_tx_count", tx_cnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
